ramp_seq_ctrl: RTL and testbench

Conversion sequencer for the single-slope ramp ADC; it drives the strobe/enable/reset side of the 6-bit conversion counter. On `start` it clears the counter, runs the ramp while the comparator reports ramp < input, and stops the counter when the comparator trips or full scale is reached. It then latches the code into `result` and pulses `done`. It sits between the ADC front-end control (start/abort) and the counter.

---
 rtl/ramp_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_ramp_seq_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_seq_ctrl.sv
// Conversion sequencer for the single-slope ramp ADC: drives strobe/clear/enable of the conversion counter.
// Optional RAMP_CMP_SYNC_EN adds a 2-flop comparator synchronizer.
module ramp_seq_ctrl #(
   parameter int CNT_W    = 6,
   parameter int STRB_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             cmp,
   input  logic [CNT_W-1:0] cnt_in,
   output logic             strb,
   output logic             cnt_rst,
   output logic             cnt_en,
   output logic             ramp_en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] result,
   output logic             ovf
);

   localparam int              PRE_W   = $clog2(STRB_DIV);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(STRB_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CLEAR   = 2'd1;
   localparam logic [1:0] S_RAMP    = 2'd2;
   localparam logic [1:0] S_CAPTURE = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_n;
   logic [PRE_W-1:0] pre;
   logic             ovf_pend;
   logic             ovf_pend_n;
   logic             cmp_s;
   logic             at_max;
   logic             run;

`ifdef RAMP_CMP_SYNC_EN
   logic [1:0] cmp_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_sync <= '0;
      end else begin
         cmp_sync <= {cmp_sync[0], cmp};
      end
   end

   assign cmp_s = cmp_sync[1];
`else
   assign cmp_s = cmp;
`endif

   assign at_max = (cnt_in == CNT_MAX);

   always_comb begin
      state_n    = state;
      ovf_pend_n = ovf_pend;
      case (state)
         S_IDLE: begin
            if (start && !abort) state_n = S_CLEAR;
         end
         S_CLEAR: begin
            if (abort)     state_n = S_IDLE;
            else if (strb) state_n = S_RAMP;
         end
         S_RAMP: begin
            // Trip is tested first so a trip coinciding with full scale reports ovf=0.
            if (abort) begin
               state_n = S_IDLE;
            end else if (!cmp_s) begin
               state_n    = S_CAPTURE;
               ovf_pend_n = 1'b0;
            end else if (at_max) begin
               state_n    = S_CAPTURE;
               ovf_pend_n = 1'b1;
            end
         end
         S_CAPTURE: state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   // Prescaler only runs while both current and next state are CLEAR/RAMP,
   // which zeroes it on CLEAR entry and keeps strb low in IDLE/CAPTURE.
   assign run = ((state == S_CLEAR) || (state == S_RAMP)) &&
                ((state_n == S_CLEAR) || (state_n == S_RAMP));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         pre      <= '0;
         strb     <= 1'b0;
         ovf_pend <= 1'b0;
         result   <= '0;
         ovf      <= 1'b0;
      end else begin
         state    <= state_n;
         ovf_pend <= ovf_pend_n;
         strb     <= run && (pre == PRE_MAX);
         if (run) begin
            pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
         end else begin
            pre <= '0;
         end
         if ((state == S_CAPTURE) && !abort) begin
            result <= cnt_in;
            ovf    <= ovf_pend;
         end
      end
   end

   assign busy    = (state != S_IDLE);
   assign cnt_rst = (state == S_CLEAR);
   assign ramp_en = (state == S_RAMP);
   assign cnt_en  = (state == S_RAMP) && cmp_s && !at_max;
   assign done    = (state == S_CAPTURE) && !abort && !rst;

endmodule

// File: tb/tb_ramp_seq_ctrl.sv
// Bench for ramp_seq_ctrl: three instances (STRB_DIV 4, 2, 7), each with a counter and comparator model,
// checked against an arithmetic model of the expected conversion code.
module tb_ramp_seq_ctrl;

`ifdef RAMP_CMP_SYNC_EN
   localparam bit SYNC = 1'b1;
`else
   localparam bit SYNC = 1'b0;
`endif
   localparam int CYC_BUDGET = 1000;

   logic clk = 1'b0;
   logic rst, start, abort;
   int   vin;

   logic       strb[3], cnt_rst[3], cnt_en[3], ramp_en[3], busy[3], done[3], ovf[3], cmp[3];
   logic [5:0] result[3];
   logic [5:0] cnt[3] = '{default: 6'd21};

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   int         done_cnt[3]    = '{default: 0};
   int         done_cyc[3]    = '{default: 0};
   int         trip_cyc[3]    = '{default: 0};
   int         strb_last[3]   = '{default: 0};
   int         strb_bad[3]    = '{default: 0};
   int         strb_total[3]  = '{default: 0};
   int         overlap_bad[3] = '{default: 0};
   int         wrap_bad[3]    = '{default: 0};
   logic       done_pend[3]   = '{default: 1'b0};
   logic       strb_valid[3]  = '{default: 1'b0};
   logic       prev_cmp[3]    = '{default: 1'b0};
   logic [5:0] done_res[3]    = '{default: 6'd0};
   logic       done_ovf[3]    = '{default: 1'b0};

   always #5 clk = ~clk;

   function automatic int div_of(input int i);
      return (i == 0) ? 4 : ((i == 1) ? 2 : 7);
   endfunction

   // Expected code: trip when the ramp reaches vin; the synchronizer delays the trip by
   // two clocks, which lets one extra strobe land only when STRB_DIV is 2.
   function automatic void expect_conv(input int v, input int div, output int code, output bit ov);
      if (v <= 0)                    begin code = 0;     ov = 1'b0; end
      else if (v >= 64)              begin code = 63;    ov = 1'b1; end
      else if (SYNC && v == 63)      begin code = 63;    ov = 1'b1; end
      else if (SYNC && div == 2)     begin code = v + 1; ov = 1'b0; end
      else                           begin code = v;     ov = 1'b0; end
   endfunction

   ramp_seq_ctrl #(.CNT_W(6), .STRB_DIV(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .cmp(cmp[0]), .cnt_in(cnt[0]),
      .strb(strb[0]), .cnt_rst(cnt_rst[0]), .cnt_en(cnt_en[0]), .ramp_en(ramp_en[0]),
      .busy(busy[0]), .done(done[0]), .result(result[0]), .ovf(ovf[0]));

   ramp_seq_ctrl #(.CNT_W(6), .STRB_DIV(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .cmp(cmp[1]), .cnt_in(cnt[1]),
      .strb(strb[1]), .cnt_rst(cnt_rst[1]), .cnt_en(cnt_en[1]), .ramp_en(ramp_en[1]),
      .busy(busy[1]), .done(done[1]), .result(result[1]), .ovf(ovf[1]));

   ramp_seq_ctrl #(.CNT_W(6), .STRB_DIV(7)) u_dut7 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .cmp(cmp[2]), .cnt_in(cnt[2]),
      .strb(strb[2]), .cnt_rst(cnt_rst[2]), .cnt_en(cnt_en[2]), .ramp_en(ramp_en[2]),
      .busy(busy[2]), .done(done[2]), .result(result[2]), .ovf(ovf[2]));

   // Ramp sits at zero while disabled, so the comparator reads "below input" for any vin > 0.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cmp[i] = ((ramp_en[i] ? int'(cnt[i]) : 0) < vin);
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 3; i++) begin
         if (strb[i]) begin
            if (cnt_rst[i])     cnt[i] <= 6'd0;
            else if (cnt_en[i]) cnt[i] <= cnt[i] + 6'd1;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         done_pend[i] <= done[i];
         if (done[i]) begin
            done_cnt[i] <= done_cnt[i] + 1;
            done_cyc[i] <= cyc;
         end
         if (done_pend[i]) begin
            done_res[i] <= result[i];
            done_ovf[i] <= ovf[i];
         end
         if (strb[i]) begin
            strb_total[i] <= strb_total[i] + 1;
            if (strb_valid[i] && (cyc - strb_last[i]) != div_of(i)) strb_bad[i] <= strb_bad[i] + 1;
            strb_last[i]  <= cyc;
            strb_valid[i] <= 1'b1;
         end else if (!busy[i]) begin
            strb_valid[i] <= 1'b0;
         end
         if (cnt_rst[i] && cnt_en[i]) overlap_bad[i] <= overlap_bad[i] + 1;
         if (strb[i] && cnt_en[i] && !cnt_rst[i] && cnt[i] == 6'd63) wrap_bad[i] <= wrap_bad[i] + 1;
         if (ramp_en[i] && prev_cmp[i] && !cmp[i]) trip_cyc[i] <= cyc;
         prev_cmp[i] <= cmp[i];
      end
   end

   task automatic run_conv(input int v, input int restart_at, output bit timed_out, output bit [2:0] busy_at_start);
      int base[3];
      int waited;
      vin = v;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) base[i] = done_cnt[i];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busy_at_start = {busy[2], busy[1], busy[0]};
      waited = 0;
      while (!(done_cnt[0] > base[0] && done_cnt[1] > base[1] && done_cnt[2] > base[2]) &&
             waited < CYC_BUDGET) begin
         start = (waited == restart_at);
         @(posedge clk); #1;
         waited++;
      end
      start = 1'b0;
      timed_out = (waited >= CYC_BUDGET);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [12:0] outs;
      rst = 1'b1; start = 1'b0; abort = 1'b0; vin = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         outs = {strb[i], cnt_rst[i], cnt_en[i], ramp_en[i], busy[i], done[i], ovf[i], result[i]};
         n_checks++;
         if (outs !== 13'd0) $display("FAIL reset_outs[%0d]: got %0h expected 0", i, outs);
         else n_pass++;
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (busy[i] !== 1'b0) $display("FAIL idle_busy[%0d]: got %0b expected 0", i, busy[i]);
         else n_pass++;
      end
   endtask

   task automatic check_conv(input string name, input int v);
      int code;
      bit ov;
      for (int i = 0; i < 3; i++) begin
         expect_conv(v, div_of(i), code, ov);
         n_checks++;
         if (done_res[i] !== 6'(code) || done_ovf[i] !== ov)
            $display("FAIL %s[%0d] vin=%0d: got code=%0d ovf=%0b expected code=%0d ovf=%0b",
                     name, i, v, done_res[i], done_ovf[i], code, ov);
         else n_pass++;
      end
   endtask

   task automatic test_normal;
      bit       to;
      bit [2:0] bs;
      run_conv(37, -1, to, bs);
      n_checks++;
      if (to) $display("FAIL normal_timeout: got timeout expected done");
      else n_pass++;
      n_checks++;
      if (bs !== 3'b111) $display("FAIL normal_busy_start: got %b expected 111", bs);
      else n_pass++;
      check_conv("normal", 37);
      repeat (20) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (cnt[i] !== done_res[i] || busy[i] !== 1'b0)
            $display("FAIL normal_hold[%0d]: got cnt=%0d busy=%0b expected cnt=%0d busy=0",
                     i, cnt[i], busy[i], done_res[i]);
         else n_pass++;
      end
      n_checks++;
      if (done_cyc[0] - trip_cyc[0] !== (SYNC ? 3 : 1))
         $display("FAIL trip_latency: got %0d expected %0d", done_cyc[0] - trip_cyc[0], SYNC ? 3 : 1);
      else n_pass++;
   endtask

   task automatic test_full_scale;
      bit       to;
      bit [2:0] bs;
      run_conv(64, -1, to, bs);
      n_checks++;
      if (to) $display("FAIL full_timeout: got timeout expected done");
      else n_pass++;
      check_conv("full_scale", 64);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (cnt[i] !== 6'd63) $display("FAIL full_cnt[%0d]: got %0d expected 63", i, cnt[i]);
         else n_pass++;
      end
      run_conv(63, -1, to, bs);
      check_conv("at_max_trip", 63);
   endtask

   task automatic test_immediate_trip;
      bit       to;
      bit [2:0] bs;
      run_conv(0, -1, to, bs);
      n_checks++;
      if (to) $display("FAIL imm_timeout: got timeout expected done");
      else n_pass++;
      check_conv("immediate", 0);
   endtask

   task automatic test_start_ignored;
      bit       to;
      bit [2:0] bs;
      int       base[3];
      for (int i = 0; i < 3; i++) base[i] = done_cnt[i];
      run_conv(20, 15, to, bs);
      repeat (10) @(posedge clk);
      #1;
      check_conv("restart", 20);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (done_cnt[i] - base[i] !== 1 || busy[i] !== 1'b0)
            $display("FAIL restart_done_count[%0d]: got %0d busy=%0b expected 1 busy=0",
                     i, done_cnt[i] - base[i], busy[i]);
         else n_pass++;
      end
   endtask

   task automatic test_abort;
      bit         to;
      bit [2:0]   bs;
      int         base[3];
      logic [5:0] prev[3];
      int         waited;
      run_conv(25, -1, to, bs);
      for (int i = 0; i < 3; i++) begin
         prev[i] = result[i];
         base[i] = done_cnt[i];
      end
      vin = 64;
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      waited = 0;
      while (!(ramp_en[0] && cnt[0] == 6'd10) && waited < CYC_BUDGET) begin
         @(posedge clk); #1;
         waited++;
      end
      n_checks++;
      if (waited >= CYC_BUDGET) $display("FAIL abort_wait: got timeout expected cnt=10");
      else n_pass++;
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (busy[i] !== 1'b0) $display("FAIL abort_busy[%0d]: got %0b expected 0", i, busy[i]);
         else n_pass++;
      end
      repeat (10) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (done_cnt[i] !== base[i] || result[i] !== prev[i])
            $display("FAIL abort_keep[%0d]: got dones=%0d result=%0d expected dones=%0d result=%0d",
                     i, done_cnt[i], result[i], base[i], prev[i]);
         else n_pass++;
      end
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (busy[i] !== 1'b0) $display("FAIL start_abort_idle[%0d]: got %0b expected 0", i, busy[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid;
      int          waited;
      logic [12:0] outs;
      vin = 64;
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      waited = 0;
      while (!(ramp_en[0] && cnt[0] >= 6'd5) && waited < CYC_BUDGET) begin
         @(posedge clk); #1;
         waited++;
      end
      n_checks++;
      if (waited >= CYC_BUDGET) $display("FAIL rst_mid_wait: got timeout expected ramp");
      else n_pass++;
      rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         outs = {strb[i], cnt_rst[i], cnt_en[i], ramp_en[i], busy[i], done[i], ovf[i], result[i]};
         n_checks++;
         if (outs !== 13'd0) $display("FAIL rst_mid_outs[%0d]: got %0h expected 0", i, outs);
         else n_pass++;
      end
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (result[i] !== 6'd0 || busy[i] !== 1'b0)
            $display("FAIL rst_mid_after[%0d]: got result=%0d busy=%0b expected 0 0", i, result[i], busy[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random;
      bit       to;
      bit [2:0] bs;
      int       v;
      repeat (6) begin
         v = int'($urandom_range(0, 64));
         run_conv(v, -1, to, bs);
         n_checks++;
         if (to) $display("FAIL random_timeout: vin=%0d got timeout expected done", v);
         else n_pass++;
         check_conv("random", v);
      end
   endtask

   task automatic test_monitors;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (strb_bad[i] !== 0 || strb_total[i] == 0)
            $display("FAIL strb_spacing[%0d]: got bad=%0d total=%0d expected bad=0 total>0",
                     i, strb_bad[i], strb_total[i]);
         else n_pass++;
         n_checks++;
         if (overlap_bad[i] !== 0 || wrap_bad[i] !== 0)
            $display("FAIL cnt_ctrl[%0d]: got overlap=%0d wrap=%0d expected 0 0", i, overlap_bad[i], wrap_bad[i]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset;
      test_normal;
      test_full_scale;
      test_immediate_trip;
      test_start_ignored;
      test_abort;
      test_reset_mid;
      test_random;
      test_monitors;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
